calcfeeder: RTL and testbench

- Source end of the correlation datapath: buffers one f window and one extended g window, then replays them to a calc unit once per shift position.
- Emits the f/g sample stream plus the pass-control strobes (lstart, startsig, work, valid, change, finalstart, startplace).
- Presents fsum/f2sum, the precomputed f-window statistics, held stable for the whole sweep.
- Sits between the pixel loader and the calc unit / formula stage.

---
 rtl/calcfeeder_pkg.sv | 23 ++
 rtl/calcfeeder_featbuf.sv | 23 ++
 rtl/calcfeeder.sv | 161 ++++++++++++++++
 tb/tb_calcfeeder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calcfeeder_pkg.sv
// Shared types and widths for the correlation datapath (feeder, calc unit, formula stage).
package calcfeeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRIME,
    SWEEP,
    FINISH
  } state_e;

  localparam int SAMPLE_W = 3;
  localparam int FSUM_W   = 11;
  localparam int F2SUM_W  = 14;
  localparam int G2SUM_W  = 14;
  localparam int PLACE_W  = 6;
  localparam int RESULT_W = 18;

  function automatic logic [5:0] sq3(input logic [SAMPLE_W-1:0] x);
    return {3'b000, x} * {3'b000, x};
  endfunction

endpackage

// File: rtl/calcfeeder_featbuf.sv
// Single-write-port sample RAM with registered (1-cycle) read.
module calcfeeder_featbuf
  import calcfeeder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [SAMPLE_W-1:0] rdata_o
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/calcfeeder.sv
// Loads one f and one extended g window, then replays them once per shift.
// CALCFEED_GAP_EN inserts a bubble cycle between passes.
module calcfeeder
  import calcfeeder_pkg::*;
#(
  parameter int WIN    = 256,
  parameter int SHIFTS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_f,
  input  logic [SAMPLE_W-1:0] in_g,
  output logic [SAMPLE_W-1:0] fdata,
  output logic [SAMPLE_W-1:0] gdata,
  output logic [FSUM_W-1:0]   fsum,
  output logic [F2SUM_W-1:0]  f2sum,
  output logic                lstart,
  output logic                startsig,
  output logic                work,
  output logic                valid,
  output logic                change,
  output logic                finalstart,
  output logic [PLACE_W-1:0]  startplace,
  output logic                done
);

  localparam int GD = WIN + SHIFTS - 1;
  localparam int IW = $clog2(WIN + 1);
  localparam int GW = $clog2(GD + 1);
`ifdef CALCFEED_GAP_EN
  localparam logic GAP = 1'b1;
`else
  localparam logic GAP = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [GW-1:0]        ld_q, ld_d;
  logic [IW-1:0]        i_q, i_d;
  logic [PLACE_W-1:0]   s_q, s_d;
  logic                 gap_q, gap_d;
  logic [FSUM_W-1:0]    fsum_q, fsum_d;
  logic [F2SUM_W-1:0]   f2sum_q, f2sum_d;
  logic                 last_i, last_s, we, vld;
  logic [SAMPLE_W-1:0]  frd, grd;

  assign last_i = (i_q == IW'(WIN - 1));
  assign last_s = (s_q == PLACE_W'(SHIFTS - 1));
  assign we     = (state_q == LOAD) && in_valid;

  // i_d/s_d always name the pair shown next cycle, so they double as read address
  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    i_d     = i_q;
    s_d     = s_q;
    gap_d   = 1'b0;
    fsum_d  = fsum_q;
    f2sum_d = f2sum_q;
    unique case (state_q)
      IDLE: begin
        i_d = '0;
        s_d = '0;
        if (start) begin
          state_d = LOAD;
          ld_d    = '0;
          fsum_d  = '0;
          f2sum_d = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          ld_d = ld_q + 1'b1;
          if (ld_q < GW'(WIN)) begin
            fsum_d  = fsum_q + FSUM_W'(in_f);
            f2sum_d = f2sum_q + F2SUM_W'(sq3(in_f));
          end
          if (ld_q == GW'(GD - 1)) state_d = PRIME;
        end
      end
      PRIME: state_d = SWEEP;
      SWEEP: begin
        if (!gap_q) begin
          if (last_i) begin
            if (last_s) begin
              state_d = FINISH;
            end else begin
              i_d   = '0;
              s_d   = s_q + 1'b1;
              gap_d = GAP;
            end
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        i_d     = '0;
        s_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ld_q    <= '0;
      i_q     <= '0;
      s_q     <= '0;
      gap_q   <= 1'b0;
      fsum_q  <= '0;
      f2sum_q <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      i_q     <= i_d;
      s_q     <= s_d;
      gap_q   <= gap_d;
      fsum_q  <= fsum_d;
      f2sum_q <= f2sum_d;
    end
  end

  calcfeeder_featbuf #(.DEPTH(WIN), .AW(IW)) u_fbuf (
    .clk    (clk),
    .we_i   (we && (ld_q < GW'(WIN))),
    .waddr_i(ld_q[IW-1:0]),
    .wdata_i(in_f),
    .raddr_i(i_d),
    .rdata_o(frd)
  );

  calcfeeder_featbuf #(.DEPTH(GD), .AW(GW)) u_gbuf (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(ld_q),
    .wdata_i(in_g),
    .raddr_i(GW'(i_d) + GW'(s_d)),
    .rdata_o(grd)
  );

  assign vld        = (state_q == SWEEP) && !gap_q;
  assign in_ready   = (state_q == LOAD);
  assign lstart     = (state_q == PRIME);
  assign work       = (state_q == PRIME) || (state_q == SWEEP);
  assign valid      = vld;
  assign startsig   = vld && (i_q == '0);
  assign change     = vld && last_i;
  assign finalstart = vld && last_s;
  assign startplace = (state_q == SWEEP) ? s_q : '0;
  assign done       = (state_q == FINISH);
  assign fdata      = vld ? frd : '0;
  assign gdata      = vld ? grd : '0;
  assign fsum       = fsum_q;
  assign f2sum      = f2sum_q;

endmodule

// File: tb/tb_calcfeeder.sv
// Directed bench for calcfeeder: small (4x2) and full-width (256x2) instances.
module tb_calcfeeder;

`ifdef CALCFEED_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 0, in_valid0 = 0;
  logic [2:0] in_f0 = 0, in_g0 = 0;
  logic       in_ready0, lstart0, startsig0, work0, valid0;
  logic       change0, finalstart0, done0;
  logic [2:0] fdata0, gdata0;
  logic [10:0] fsum0;
  logic [13:0] f2sum0;
  logic [5:0] startplace0;

  logic       start1 = 0, in_valid1 = 0;
  logic [2:0] in_f1 = 0, in_g1 = 0;
  logic       in_ready1, lstart1, startsig1, work1, valid1;
  logic       change1, finalstart1, done1;
  logic [2:0] fdata1, gdata1;
  logic [10:0] fsum1;
  logic [13:0] f2sum1;
  logic [5:0] startplace1;

  calcfeeder #(.WIN(4), .SHIFTS(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(in_valid0),
    .in_ready(in_ready0), .in_f(in_f0), .in_g(in_g0),
    .fdata(fdata0), .gdata(gdata0), .fsum(fsum0), .f2sum(f2sum0),
    .lstart(lstart0), .startsig(startsig0), .work(work0), .valid(valid0),
    .change(change0), .finalstart(finalstart0),
    .startplace(startplace0), .done(done0)
  );

  calcfeeder #(.WIN(256), .SHIFTS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1),
    .in_ready(in_ready1), .in_f(in_f1), .in_g(in_g1),
    .fdata(fdata1), .gdata(gdata1), .fsum(fsum1), .f2sum(f2sum1),
    .lstart(lstart1), .startsig(startsig1), .work(work1), .valid(valid1),
    .change(change1), .finalstart(finalstart1),
    .startplace(startplace1), .done(done1)
  );

  // {lstart,startsig,work,valid,change,finalstart,startplace,fdata,gdata,done}
  logic [18:0] obs0;
  assign obs0 = {lstart0, startsig0, work0, valid0, change0, finalstart0,
                 startplace0, fdata0, gdata0, done0};

  logic [2:0] F [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [2:0] G [5] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

  function automatic logic [18:0] mk(input logic l, ss, w, v, c, fs,
                                      input logic [5:0] sp,
                                      input logic [2:0] f, g,
                                      input logic d);
    return {l, ss, w, v, c, fs, sp, f, g, d};
  endfunction

  task automatic do_load(input string nm, input bit stall);
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    n_chk++;
    if (in_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready_load got %b exp 1", nm, in_ready0);
    end
    for (int k = 0; k < 5; k++) begin
      if (stall && k > 0) begin
        in_valid0 = 1'b0;
        in_f0 = 3'd7;
        in_g0 = 3'd7;
        repeat (2) @(negedge clk);
      end
      in_valid0 = 1'b1;
      in_f0 = (k < 4) ? F[k] : 3'd7;
      in_g0 = G[k];
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    n_chk++;
    if (in_ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s in_ready_drop got %b exp 0", nm, in_ready0);
    end
    n_chk++;
    if (fsum0 !== 11'd10 || f2sum0 !== 14'd30) begin
      n_fail++;
      $display("FAIL %s sums got %0d/%0d exp 10/30", nm, fsum0, f2sum0);
    end
  endtask

  // Entered at the PRIME cycle; stop_at>=0 returns right after that pair.
  task automatic check_sweep(input string nm, input int stop_at,
                             input bit poke);
    logic [18:0] e;
    int i, s;
    e = mk(1, 0, 1, 0, 0, 0, 6'd0, 3'd0, 3'd0, 0);
    n_chk++;
    if (obs0 !== e) begin
      n_fail++;
      $display("FAIL %s prime got %h exp %h", nm, obs0, e);
    end
    for (int n = 0; n < 8; n++) begin
      i = n % 4;
      s = n / 4;
      if (GAP != 0 && n == 4) begin
        @(negedge clk);
        e = mk(0, 0, 1, 0, 0, 0, 6'd1, 3'd0, 3'd0, 0);
        n_chk++;
        if (obs0 !== e) begin
          n_fail++;
          $display("FAIL %s bubble got %h exp %h", nm, obs0, e);
        end
      end
      @(negedge clk);
      e = mk(0, i == 0, 1, 1, i == 3, s == 1, 6'(s), F[i], G[i+s], 0);
      n_chk++;
      if (obs0 !== e) begin
        n_fail++;
        $display("FAIL %s pair%0d got %h exp %h", nm, n, obs0, e);
      end
      if (n == stop_at) return;
      if (poke) start0 = (n == 2);
    end
    @(negedge clk);
    e = mk(0, 0, 0, 0, 0, 0, 6'd0, 3'd0, 3'd0, 1);
    n_chk++;
    if (obs0 !== e) begin
      n_fail++;
      $display("FAIL %s finish got %h exp %h", nm, obs0, e);
    end
    @(negedge clk);
    n_chk++;
    if (obs0 !== 19'd0 || in_ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle got %h/%b exp 0/0", nm, obs0, in_ready0);
    end
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (obs0 !== 19'd0 || in_ready0 !== 1'b0 || fsum0 !== 11'd0 ||
        f2sum0 !== 14'd0) begin
      n_fail++;
      $display("FAIL reset got %h/%b/%0d/%0d exp all 0",
               obs0, in_ready0, fsum0, f2sum0);
    end
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_load("basic", 0);
    check_sweep("basic", -1, 0);
    n_chk++;
    if (fsum0 !== 11'd10 || f2sum0 !== 14'd30) begin
      n_fail++;
      $display("FAIL basic_hold got %0d/%0d exp 10/30", fsum0, f2sum0);
    end
  endtask

  task automatic test_stall();
    do_load("stall", 1);
    check_sweep("stall", -1, 0);
  endtask

  task automatic test_start_ignored();
    do_load("poke", 0);
    check_sweep("poke", -1, 1);
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if (in_ready0 !== 1'b0 || done0 !== 1'b0) begin
        n_fail++;
        $display("FAIL poke_after got %b/%b exp 0/0", in_ready0, done0);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_load("rstmid", 0);
    check_sweep("rstmid", 6, 0);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs0 !== 19'd0 || in_ready0 !== 1'b0 || fsum0 !== 11'd0 ||
        f2sum0 !== 14'd0) begin
      n_fail++;
      $display("FAIL rstmid_zero got %h/%b/%0d/%0d exp all 0",
               obs0, in_ready0, fsum0, f2sum0);
    end
    @(negedge clk) rst_n = 1'b1;
    do_load("rerun", 0);
    check_sweep("rerun", -1, 0);
  endtask

  task automatic test_big();
    int nv, wc, cyc;
    logic [2:0] eg;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int k = 0; k < 257; k++) begin
      in_valid1 = 1'b1;
      in_f1 = 3'd7;
      in_g1 = 3'(k);
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    n_chk++;
    if (fsum1 !== 11'd1792 || f2sum1 !== 14'd12544 || lstart1 !== 1'b1) begin
      n_fail++;
      $display("FAIL big_sums got %0d/%0d/%b exp 1792/12544/1",
               fsum1, f2sum1, lstart1);
    end
    nv = 0;
    wc = 0;
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done1) break;
      if (work1) wc++;
      if (valid1) begin
        eg = 3'((nv % 256) + (nv / 256));
        n_chk++;
        if (fdata1 !== 3'd7 || gdata1 !== eg) begin
          n_fail++;
          $display("FAIL big_pair%0d got %0d/%0d exp 7/%0d",
                   nv, fdata1, gdata1, eg);
        end
        nv++;
      end
    end
    n_chk++;
    if (done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL big_timeout got done %b exp 1", done1);
    end
    n_chk++;
    if (nv != 512 || wc != 512 + GAP) begin
      n_fail++;
      $display("FAIL big_len got %0d/%0d exp 512/%0d", nv, wc, 512 + GAP);
    end
    n_chk++;
    if (fsum1 !== 11'd1792 || f2sum1 !== 14'd12544) begin
      n_fail++;
      $display("FAIL big_hold got %0d/%0d exp 1792/12544", fsum1, f2sum1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_big();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
